// File: rtl/seed_host_ctrl.sv
// Host-side sequencer for the SEED-128 core: loads {1,text} then {dec,key}
// on the 129-bit command port, waits for done (with a watchdog) and returns the result.
module seed_host_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Req_Valid,
    output logic         o_Req_Ready,
    input  logic         i_Req_Dec,
    input  logic [127:0] i_Req_Key,
    input  logic [127:0] i_Req_Text,
    output logic [128:0] o_Core_Data,
    input  logic [127:0] i_Core_Text,
    input  logic         i_Core_Done,
    output logic         o_Rsp_Valid,
    input  logic         i_Rsp_Ready,
    output logic [127:0] o_Rsp_Text,
    output logic         o_Rsp_Err,
    output logic         o_Busy
);

    localparam int DATA_W = 128;
    localparam int WD_W   = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_TEXT,
        ST_SEND_KEY,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WD_W-1:0]   wdog;
    logic              wd_expired;
    logic              accept;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] text_q;
    logic              dec_q;
    logic [DATA_W-1:0] rsp_text;
    logic              rsp_err;

    assign accept     = (state == ST_IDLE) && i_Req_Valid;
    assign wd_expired = (wdog == WD_LAST);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_Core_Data = '0;
        case (state)
            ST_IDLE: begin
                if (i_Req_Valid) begin
                    state_nxt = ST_SEND_TEXT;
                end
            end
            ST_SEND_TEXT: begin
                o_Core_Data = {1'b1, text_q};
                state_nxt   = ST_SEND_KEY;
            end
            ST_SEND_KEY: begin
                o_Core_Data = {dec_q, key_q};
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_Core_Done || wd_expired) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_Rsp_Ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request operands are pure data: captured on accept, never reset.
    always_ff @(posedge i_Clk) begin
        if (accept) begin
            key_q  <= i_Req_Key;
            text_q <= i_Req_Text;
            dec_q  <= i_Req_Dec;
        end
    end

    // Watchdog never wraps: reaching WD_LAST always leaves WAIT.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            wdog <= '0;
        end else if (state == ST_SEND_KEY) begin
            wdog <= '0;
        end else if (state == ST_WAIT) begin
            wdog <= wdog + 1'b1;
        end
    end

    // Done takes priority over an expiring watchdog in the same cycle.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            rsp_text <= '0;
            rsp_err  <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (i_Core_Done) begin
                rsp_text <= i_Core_Text;
                rsp_err  <= 1'b0;
            end else if (wd_expired) begin
                rsp_text <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

    assign o_Req_Ready = (state == ST_IDLE);
    assign o_Rsp_Valid = (state == ST_RESP);
    assign o_Busy      = (state != ST_IDLE);
    assign o_Rsp_Text  = rsp_text;
    assign o_Rsp_Err   = rsp_err;

endmodule

// File: tb/tb_seed_host_ctrl.sv
// Bench for seed_host_ctrl: a cycle-counting core stub driven from tasks, plus a
// second instance with a short watchdog for the timeout scenarios.
module tb_seed_host_ctrl;

    localparam logic [127:0] KAT_PT = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KAT_CT = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
    localparam int ENC_LAT = 80;
    localparam int DEC_LAT = 112;
    localparam int TO_CYC  = 50;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_dec;
    logic [127:0] req_key;
    logic [127:0] req_text;
    logic [127:0] core_text;
    logic         core_done;
    logic         rsp_ready;

    logic         req_ready, rsp_valid, rsp_err, busy;
    logic [128:0] core_data;
    logic [127:0] rsp_text;
    logic         t_req_ready, t_rsp_valid, t_rsp_err, t_busy;
    logic [128:0] t_core_data;
    logic [127:0] t_rsp_text;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seed_host_ctrl dut (
        .i_Clk(clk), .i_Rst(rst_n),
        .i_Req_Valid(req_valid), .o_Req_Ready(req_ready), .i_Req_Dec(req_dec),
        .i_Req_Key(req_key), .i_Req_Text(req_text), .o_Core_Data(core_data),
        .i_Core_Text(core_text), .i_Core_Done(core_done),
        .o_Rsp_Valid(rsp_valid), .i_Rsp_Ready(rsp_ready),
        .o_Rsp_Text(rsp_text), .o_Rsp_Err(rsp_err), .o_Busy(busy)
    );

    seed_host_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut_to (
        .i_Clk(clk), .i_Rst(rst_n),
        .i_Req_Valid(req_valid), .o_Req_Ready(t_req_ready), .i_Req_Dec(req_dec),
        .i_Req_Key(req_key), .i_Req_Text(req_text), .o_Core_Data(t_core_data),
        .i_Core_Text(core_text), .i_Core_Done(core_done),
        .o_Rsp_Valid(t_rsp_valid), .i_Rsp_Ready(rsp_ready),
        .o_Rsp_Text(t_rsp_text), .o_Rsp_Err(t_rsp_err), .o_Busy(t_busy)
    );

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference timing: done lands lat cycles after SEND_KEY (cycle 2), response one edge later.
    function automatic int exp_vld_cycle(input int lat);
        return 2 + lat + 1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one request, acts as the core (done pulse `lat` cycles after SEND_KEY,
    // lat < 0 = never) and checks the command word on every cycle.
    task automatic run_txn(input logic [127:0] key, input logic [127:0] text, input logic dec,
                           input int lat, input logic [127:0] res,
                           output int vc, output logic [127:0] got_text, output logic got_err);
        logic [128:0] exp_cd;
        int done_at;
        done_at  = (lat < 0) ? -1 : 2 + lat;
        vc       = -1;
        got_text = '0;
        got_err  = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL txn_ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_key   = key;
        req_text  = text;
        req_dec   = dec;
        for (int c = 1; c <= 400 && vc < 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            exp_cd = (c == 1) ? {1'b1, text} : (c == 2) ? {dec, key} : 129'd0;
            total++;
            if (core_data !== exp_cd) begin
                bad++;
                $display("FAIL cmd_word c=%0d: got %h want %h", c, core_data, exp_cd);
            end
            if (rsp_valid === 1'b1) begin
                vc       = c;
                got_text = rsp_text;
                got_err  = rsp_err;
            end
            core_done = (c == done_at);
            core_text = rnd128();
            if (c == done_at) core_text = res;
        end
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_dec = 1'b0; req_key = '0; req_text = '0;
        core_text = '0; core_done = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        total++; if (core_data !== 129'd0) begin bad++; $display("FAIL rst_core_data: got %h want 0", core_data); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_text !== 128'd0) begin bad++; $display("FAIL rst_rsp_text: got %h want 0", rsp_text); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (t_busy !== 1'b0) begin bad++; $display("FAIL rst_t_busy: got %b want 0", t_busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_kat();
        int vc; logic [127:0] gt; logic ge;
        run_txn(128'd0, KAT_PT, 1'b0, ENC_LAT, KAT_CT, vc, gt, ge);
        total++; if (vc != 83) begin bad++; $display("FAIL enc_vld_cycle: got %0d want 83", vc); end
        total++; if (gt !== KAT_CT) begin bad++; $display("FAIL enc_text: got %h want %h", gt, KAT_CT); end
        total++; if (ge !== 1'b0) begin bad++; $display("FAIL enc_err: got %b want 0", ge); end
        run_txn(128'd0, KAT_CT, 1'b1, DEC_LAT, KAT_PT, vc, gt, ge);
        total++; if (vc != 115) begin bad++; $display("FAIL dec_vld_cycle: got %0d want 115", vc); end
        total++; if (gt !== KAT_PT) begin bad++; $display("FAIL dec_text: got %h want %h", gt, KAT_PT); end
        total++; if (ge !== 1'b0) begin bad++; $display("FAIL dec_err: got %b want 0", ge); end
    endtask

    task automatic test_random();
        int vc, lat; logic [127:0] gt, k, t, r; logic ge, d;
        for (int i = 0; i < 4; i++) begin
            k = rnd128(); t = rnd128(); r = rnd128();
            d = 1'($urandom_range(0, 1));
            lat = d ? DEC_LAT : ENC_LAT;
            run_txn(k, t, d, lat, r, vc, gt, ge);
            total++; if (vc != exp_vld_cycle(lat)) begin bad++; $display("FAIL rnd_vld_cycle[%0d]: got %0d want %0d", i, vc, exp_vld_cycle(lat)); end
            total++; if (gt !== r) begin bad++; $display("FAIL rnd_text[%0d]: got %h want %h", i, gt, r); end
            total++; if (ge !== 1'b0) begin bad++; $display("FAIL rnd_err[%0d]: got %b want 0", i, ge); end
        end
    endtask

    task automatic test_spurious_done();
        int seen_vld = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || core_data !== 129'd0) seen_vld++;
            core_done = (c < 5);
            core_text = rnd128();
        end
        core_done = 1'b0;
        total++; if (seen_vld != 0) begin bad++; $display("FAIL spurious_done: got %0d active cycles want 0", seen_vld); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL spurious_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_timeout();
        int vc; logic [127:0] gt, r; logic ge;
        for (int part = 0; part < 2; part++) begin
            do_reset();
            r = rnd128();
            vc = -1; gt = '0; ge = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_key = rnd128(); req_text = rnd128(); req_dec = 1'b0;
            for (int c = 1; c <= 200 && vc < 0; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (t_rsp_valid === 1'b1) begin vc = c; gt = t_rsp_text; ge = t_rsp_err; end
                core_done = (part == 0) && (c == 2 + TO_CYC);
                core_text = core_done ? r : rnd128();
            end
            core_done = 1'b0;
            total++; if (vc != exp_vld_cycle(TO_CYC)) begin bad++; $display("FAIL to_vld_cycle[%0d]: got %0d want %0d", part, vc, exp_vld_cycle(TO_CYC)); end
            if (part == 0) begin
                total++; if (ge !== 1'b0) begin bad++; $display("FAIL to_tie_err: got %b want 0", ge); end
                total++; if (gt !== r) begin bad++; $display("FAIL to_tie_text: got %h want %h", gt, r); end
            end else begin
                total++; if (ge !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", ge); end
                total++; if (gt !== 128'd0) begin bad++; $display("FAIL to_text: got %h want 0", gt); end
            end
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1, t1, r1, k2, t2, r2, gt;
        logic d2, ge;
        int vc, hold_bad;
        k1 = rnd128(); t1 = rnd128(); r1 = rnd128();
        k2 = rnd128(); t2 = rnd128(); r2 = rnd128(); d2 = 1'b1;
        rsp_ready = 1'b0;
        vc = -1;
        @(negedge clk);
        req_valid = 1'b1; req_key = k1; req_text = t1; req_dec = 1'b0;
        for (int c = 1; c <= 200 && vc < 0; c++) begin
            @(negedge clk);
            req_key = k2; req_text = t2; req_dec = d2;
            if (rsp_valid === 1'b1) vc = c;
            core_done = (c == 2 + ENC_LAT);
            core_text = core_done ? r1 : rnd128();
        end
        core_done = 1'b0;
        total++; if (vc != 83) begin bad++; $display("FAIL bp_vld_cycle: got %0d want 83", vc); end
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid !== 1'b1 || rsp_text !== r1 || req_ready !== 1'b0 || busy !== 1'b1) hold_bad++;
            @(negedge clk);
        end
        total++; if (hold_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); end
        total++; if (rsp_text !== r1) begin bad++; $display("FAIL bp_text: got %h want %h", rsp_text, r1); end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (core_data !== {1'b1, t2}) begin bad++; $display("FAIL bp_next_text: got %h want %h", core_data, {1'b1, t2}); end
        @(negedge clk);
        total++; if (core_data !== {d2, k2}) begin bad++; $display("FAIL bp_next_key: got %h want %h", core_data, {d2, k2}); end
        vc = -1; gt = '0; ge = 1'b1;
        for (int c = 3; c <= 300 && vc < 0; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin vc = c; gt = rsp_text; ge = rsp_err; end
            core_done = (c == 2 + DEC_LAT);
            core_text = core_done ? r2 : rnd128();
        end
        core_done = 1'b0;
        total++; if (vc != exp_vld_cycle(DEC_LAT)) begin bad++; $display("FAIL bp2_vld_cycle: got %0d want %0d", vc, exp_vld_cycle(DEC_LAT)); end
        total++; if (gt !== r2 || ge !== 1'b0) begin bad++; $display("FAIL bp2_rsp: got %h/%b want %h/0", gt, ge, r2); end
    endtask

    task automatic test_reset_mid_wait();
        int vc, stray; logic [127:0] gt; logic ge;
        stray = 0;
        @(negedge clk);
        req_valid = 1'b1; req_key = rnd128(); req_text = rnd128(); req_dec = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c == 40) begin
                rst_n = 1'b0;
                #1;
                total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
                total++; if (rsp_text !== 128'd0) begin bad++; $display("FAIL mid_rst_text: got %h want 0", rsp_text); end
                total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || core_data !== 129'd0) begin
                    bad++; $display("FAIL mid_rst_outs: got vld=%b err=%b cd=%h want 0/0/0", rsp_valid, rsp_err, core_data);
                end
            end
            if (c == 43) rst_n = 1'b1;
            if (c > 40 && (rsp_valid !== 1'b0 || busy !== 1'b0)) stray++;
            core_done = (c == 2 + ENC_LAT);
            core_text = rnd128();
        end
        core_done = 1'b0;
        total++; if (stray != 0) begin bad++; $display("FAIL mid_rst_no_rsp: got %0d active cycles want 0", stray); end
        run_txn(128'd0, KAT_PT, 1'b0, ENC_LAT, KAT_CT, vc, gt, ge);
        total++; if (vc != 83 || gt !== KAT_CT || ge !== 1'b0) begin
            bad++; $display("FAIL post_rst_enc: got c=%0d %h/%b want c=83 %h/0", vc, gt, ge, KAT_CT);
        end
    endtask

    initial begin
        test_reset();
        test_kat();
        test_random();
        test_spurious_done();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/seed_host_ctrl.md
# seed_host_ctrl

Host-side sequencer for the SEED-128 core's 129-bit command port. It accepts one cipher request (key, text, mode) over a valid/ready handshake and issues the core's two-word load sequence: `{1, text}` first, then `{dec, key}`. It then waits for the core's one-cycle done pulse, captures the 128-bit result and returns it over a valid/ready response channel. A watchdog flags a core that never finishes.

## Interface
Parameters:
- TIMEOUT_CYC, default 255: maximum WAIT cycles before a timeout error; must be > 112.

Ports (reset i_Rst, asynchronous, active-low; clock i_Clk):
- i_Clk  in  1  clock
- i_Rst  in  1  asynchronous active-low reset
- i_Req_Valid  in  1  request present
- o_Req_Ready  out  1  request accepted when high with i_Req_Valid
- i_Req_Dec  in  1  1 = decrypt, 0 = encrypt
- i_Req_Key  in  128  cipher key
- i_Req_Text  in  128  plaintext/ciphertext
- o_Core_Data  out  129  to core i_Data; bit 128 = load-start/mode flag
- i_Core_Text  in  128  core result (o_Text)
- i_Core_Done  in  1  core one-cycle done pulse (o_fDone)
- o_Rsp_Valid  out  1  response present
- i_Rsp_Ready  in  1  response consumed when high with o_Rsp_Valid
- o_Rsp_Text  out  128  result text
- o_Rsp_Err  out  1  1 = timeout, result invalid
- o_Busy  out  1  high in every state except IDLE

## Operation
- State register, five states:
  - IDLE: o_Req_Ready = 1. On i_Req_Valid, register key, text and dec, then go to SEND_TEXT.
  - SEND_TEXT: o_Core_Data = {1'b1, text}. Go to SEND_KEY unconditionally.
  - SEND_KEY: o_Core_Data = {dec, key}. Clear the watchdog and go to WAIT.
  - WAIT: o_Core_Data = 0.
    - Watchdog increments every cycle.
    - On i_Core_Done: capture i_Core_Text into o_Rsp_Text, set o_Rsp_Err = 0, go to RESP.
    - Otherwise, when watchdog == TIMEOUT_CYC-1: set o_Rsp_Text = 0, o_Rsp_Err = 1, go to RESP.
    - i_Core_Done wins over timeout in the same cycle.
  - RESP: o_Rsp_Valid = 1 with text and err held stable. On i_Rsp_Ready, go to IDLE.
- o_Core_Data is 0 in IDLE, WAIT and RESP. Bit 128 is high only in SEND_TEXT, and in SEND_KEY only when dec = 1.
- i_Core_Done outside WAIT is ignored.
- i_Req_Valid outside IDLE is ignored; o_Req_Ready is low there.
- Watchdog is 8 bits wide at the default setting, sized as clog2(TIMEOUT_CYC). It does not wrap, because a timeout exits WAIT.
- After a timeout the core is in an unknown state. The system must assert i_Rst (shared with the core) before issuing the next request. The block itself returns to IDLE normally.

## Timing
- Reset: state IDLE, o_Req_Ready = 1, o_Core_Data = 0, o_Rsp_Valid = 0, o_Rsp_Text = 0, o_Rsp_Err = 0, o_Busy = 0, watchdog = 0.
- Cycle numbering, where cycle 0 is the accepting edge:
  - Cycle 1: SEND_TEXT.
  - Cycle 2: SEND_KEY.
  - Cycle 3: WAIT begins.
- i_Core_Done arrives 80 cycles after the SEND_KEY cycle for encrypt, and 112 cycles after for decrypt (includes the core's 32 key-advance cycles).
- o_Rsp_Valid rises on the edge after the done cycle:
  - encrypt: cycle 83 after accept;
  - decrypt: cycle 115 after accept.
- Minimum spacing between accepts is one RESP cycle plus one IDLE cycle after the done cycle. The core is back in its idle state by then.
- Reset asserted mid-operation forces IDLE immediately. Any in-flight response is discarded and no o_Rsp_Valid is produced.
- Back-pressure on the response channel is unbounded; the core stays idle meanwhile.

## Test plan
- Encrypt known answer, real core:
  - key = 0, text = 000102030405060708090A0B0C0D0E0F, dec = 0.
  - Required: o_Rsp_Text = 5EBAC6E0054E166819AFF1CC6D346CDB, o_Rsp_Err = 0, o_Rsp_Valid at cycle 83.
- Decrypt of the encrypt result, key = 0, dec = 1:
  - Required: o_Rsp_Text = 000102030405060708090A0B0C0D0E0F, o_Rsp_Valid at cycle 115.
- Command-port check, core stub:
  - Cycle 1: o_Core_Data = {1, text}.
  - Cycle 2: o_Core_Data = {dec, key}.
  - Required: o_Core_Data = 0 on every other cycle, and a spurious i_Core_Done in IDLE produces no response.
- Timeout, TIMEOUT_CYC = 50, stub never pulses done:
  - Required: o_Rsp_Valid with o_Rsp_Err = 1 and o_Rsp_Text = 0, 50 WAIT cycles after SEND_KEY.
  - Also: done and timeout in the same cycle gives err = 0.
- Response back-pressure and request blocking:
  - Stimulus: i_Rsp_Ready held low for 20 cycles while i_Req_Valid is held high.
  - Required: text stable, o_Req_Ready = 0 throughout, next request accepted exactly one cycle after the response handshake.
- Reset mid-WAIT, cycle 40:
  - Required: all outputs return to reset values asynchronously.
  - Required: no response is issued, and a following encrypt request completes correctly.
